// File: rtl/execute_unit_if.sv
// Register-file-side bus of the execute stage: operand/opcode request in,
// write strike, result and flags out.
interface execute_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [2:0]  dstIn;
  logic [15:0] dataA;
  logic [15:0] dataB;
  logic        RFwrite;
  logic [2:0]  regW;
  logic [15:0] dataW;
  logic        busy;
  logic        done;
  logic        Z;
  logic        N;
  logic        C;

  modport master (
    output start, op, dstIn, dataA, dataB,
    input  RFwrite, regW, dataW, busy, done, Z, N, C
  );

  modport slave (
    input  start, op, dstIn, dataA, dataB,
    output RFwrite, regW, dataW, busy, done, Z, N, C
  );
endinterface

// File: rtl/execute_unit.sv
// Execute stage of the 16-bit CPU: single-cycle ALU ops plus a 16-iteration
// shift-add multiply, writing the register file for exactly one cycle per op.
module execute_unit (
  input  logic         CLK,
  input  logic         reset,
  execute_unit_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_mcand;
  logic [15:0] r_mplier;
  logic [15:0] r_acc;
  logic [3:0]  r_cnt;
  logic [2:0]  r_dst;
  logic [15:0] r_dataW;
  logic [2:0]  r_regW;
  logic        r_rfwrite;
  logic        r_Z;
  logic        r_N;
  logic        r_C;
  logic [16:0] w_alu;
  logic [15:0] w_acc_next;

  // Returns {carry, result}; carry is only meaningful for ADD/SUB.
  function automatic logic [16:0] alu_op(input logic [2:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    logic [16:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {(a >= b), a - b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_SHL:  r = {1'b0, a << b[3:0]};
      OP_SHR:  r = {1'b0, a >> b[3:0]};
      default: r = {1'b0, b};
    endcase
    return r;
  endfunction

  assign w_alu      = alu_op(bus.op, bus.dataA, bus.dataB);
  assign w_acc_next = r_mplier[0] ? r_acc + r_mcand : r_acc;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.start && bus.op == OP_MUL) w_next_state = MUL;
      MUL:     if (r_cnt == 4'd15) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_dst     <= '0;
      r_dataW   <= '0;
      r_regW    <= '0;
      r_rfwrite <= 1'b0;
      r_Z       <= 1'b0;
      r_N       <= 1'b0;
      r_C       <= 1'b0;
    end else begin
      r_rfwrite <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.start && bus.op != OP_MUL) begin
          r_dataW   <= w_alu[15:0];
          r_regW    <= bus.dstIn;
          r_rfwrite <= 1'b1;
          r_Z       <= (w_alu[15:0] == 16'h0000);
          r_N       <= w_alu[15];
          r_C       <= (bus.op == OP_ADD || bus.op == OP_SUB) ? w_alu[16] : 1'b0;
        end else if (bus.start) begin
          r_mcand  <= bus.dataA;
          r_mplier <= bus.dataB;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_dst    <= bus.dstIn;
        end
      end else begin
        // One shift-add step per cycle; the 16th step writes back directly.
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 4'd1;
        if (r_cnt == 4'd15) begin
          r_dataW   <= w_acc_next;
          r_regW    <= r_dst;
          r_rfwrite <= 1'b1;
          r_Z       <= (w_acc_next == 16'h0000);
          r_N       <= w_acc_next[15];
          r_C       <= 1'b0;
        end
      end
    end
  end

  assign bus.RFwrite = r_rfwrite;
  assign bus.done    = r_rfwrite;
  assign bus.regW    = r_regW;
  assign bus.dataW   = r_dataW;
  assign bus.busy    = (r_state == MUL);
  assign bus.Z       = r_Z;
  assign bus.N       = r_N;
  assign bus.C       = r_C;
endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit: behavioural model with per-cycle compare, plus
// directed vectors with hand-computed results.
module tb_execute_unit;
  logic CLK = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic chk_en   = 1'b0;

  execute_unit_if bus ();

  execute_unit dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         SHL = 3'd4, SHR = 3'd5, MUL = 3'd6, MV = 3'd7;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result {carry, value} from the arithmetic rules.
  function automatic logic [16:0] model_res(input logic [2:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
    int unsigned ua, ub, p;
    ua = a;
    ub = b;
    case (op)
      ADD:  p = ua + ub;
      SUB:  p = ((ua >= ub) ? 32'h10000 : 32'h0) | ((ua - ub) & 32'hFFFF);
      AND_: p = ua & ub;
      OR_:  p = ua | ub;
      SHL:  p = (ua << (ub % 16)) & 32'hFFFF;
      SHR:  p = ua >> (ub % 16);
      MUL:  p = (ua * ub) & 32'hFFFF;
      default: p = ub;
    endcase
    return p[16:0];
  endfunction

  // Model state: cycles of multiply still outstanding and the pending product.
  int          m_left = 0;
  logic [15:0] m_prod = '0;
  logic [2:0]  m_dst  = '0;
  logic        e_rf = 1'b0, e_Z = 1'b0, e_N = 1'b0, e_C = 1'b0;
  logic [15:0] e_dataW = '0;
  logic [2:0]  e_regW  = '0;

  always @(posedge CLK) begin
    logic [16:0] r;
    if (reset) begin
      m_left = 0; e_rf = 0; e_Z = 0; e_N = 0; e_C = 0; e_dataW = '0; e_regW = '0;
    end else begin
      e_rf = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          e_rf = 1'b1; e_dataW = m_prod; e_regW = m_dst;
          e_Z = (m_prod == 0); e_N = m_prod[15]; e_C = 1'b0;
        end
      end else if (bus.start) begin
        r = model_res(bus.op, bus.dataA, bus.dataB);
        if (bus.op == MUL) begin
          m_left = 16; m_prod = r[15:0]; m_dst = bus.dstIn;
        end else begin
          e_rf = 1'b1; e_dataW = r[15:0]; e_regW = bus.dstIn;
          e_Z = (r[15:0] == 0); e_N = r[15];
          e_C = (bus.op == ADD || bus.op == SUB) ? r[16] : 1'b0;
        end
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    if (chk_en) begin
      chk("cyc_RFwrite", bus.RFwrite, e_rf);
      chk("cyc_done",    bus.done,    e_rf);
      chk("cyc_busy",    bus.busy,    m_left > 0);
      chk("cyc_dataW",   bus.dataW,   e_dataW);
      chk("cyc_regW",    bus.regW,    e_regW);
      chk("cyc_flags",   {bus.Z, bus.N, bus.C}, {e_Z, e_N, e_C});
    end
  end

  task automatic drive(input logic st, input logic [2:0] o, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] d);
    @(negedge CLK);
    bus.start = st; bus.op = o; bus.dataA = a; bus.dataB = b; bus.dstIn = d;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 16'h0, 16'h0, 3'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.op = 0; bus.dataA = 0; bus.dataB = 0; bus.dstIn = 0;

    chk("model_add", model_res(ADD, 16'h7FFF, 16'h0001), 17'h08000);
    chk("model_sub", model_res(SUB, 16'h0000, 16'h0001), 17'h0FFFF);
    chk("model_mul", model_res(MUL, 16'h0123, 16'h0010), 17'h01230);
    chk("model_shl", model_res(SHL, 16'h0001, 16'h001F), 17'h08000);

    repeat (2) @(negedge CLK);
    chk("rst_out", {bus.RFwrite, bus.done, bus.busy, bus.Z, bus.N, bus.C}, 6'b0);
    chk("rst_dataW", bus.dataW, 16'h0000);
    chk("rst_regW", bus.regW, 3'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    drive(1, ADD, 16'h7FFF, 16'h0001, 3'd3);
    idle();
    chk("add_rf", {bus.RFwrite, bus.done}, 2'b11);
    chk("add_regW", bus.regW, 3'd3);
    chk("add_dataW", bus.dataW, 16'h8000);
    chk("add_ZNC", {bus.Z, bus.N, bus.C}, 3'b010);
    idle();
    chk("add_rf_off", bus.RFwrite, 1'b0);
    chk("add_hold", bus.dataW, 16'h8000);

    drive(1, SUB, 16'h0005, 16'h0005, 3'd1);
    drive(1, SUB, 16'h0000, 16'h0001, 3'd2);
    chk("sub0_dataW", bus.dataW, 16'h0000);
    chk("sub0_ZNC", {bus.Z, bus.N, bus.C}, 3'b101);
    idle();
    chk("sub1_rf", bus.RFwrite, 1'b1);
    chk("sub1_dataW", bus.dataW, 16'hFFFF);
    chk("sub1_ZNC", {bus.Z, bus.N, bus.C}, 3'b010);
    chk("sub1_regW", bus.regW, 3'd2);
    idle();

    drive(1, MUL, 16'h0123, 16'h0010, 3'd7);
    for (int i = 1; i <= 16; i++) begin
      idle();
      chk("mul1_busy", {bus.busy, bus.RFwrite}, 2'b10);
    end
    drive(1, OR_, 16'h00F0, 16'h000F, 3'd6);
    chk("mul1_rf", {bus.RFwrite, bus.busy}, 2'b10);
    chk("mul1_dataW", bus.dataW, 16'h1230);
    chk("mul1_regW", bus.regW, 3'd7);
    idle();
    chk("or_after_mul", {bus.RFwrite, bus.regW, bus.dataW}, {1'b1, 3'd6, 16'h00FF});
    idle();

    drive(1, MUL, 16'h0100, 16'h0100, 3'd1);
    for (int i = 1; i <= 16; i++) begin
      if (i == 5) drive(1, ADD, 16'h0001, 16'h0001, 3'd2);
      else        idle();
      chk("mul2_busy", {bus.busy, bus.RFwrite}, 2'b10);
    end
    idle();
    chk("mul2_rf", bus.RFwrite, 1'b1);
    chk("mul2_dataW", bus.dataW, 16'h0000);
    chk("mul2_ZNC", {bus.Z, bus.N, bus.C}, 3'b100);
    chk("mul2_regW", bus.regW, 3'd1);
    idle();
    chk("mul2_no_extra", bus.RFwrite, 1'b0);

    drive(1, SHL, 16'h0001, 16'h001F, 3'd0);
    drive(1, SHR, 16'h8000, 16'h0004, 3'd5);
    chk("shl_dataW", bus.dataW, 16'h8000);
    idle();
    chk("shr_dataW", bus.dataW, 16'h0800);
    drive(1, MV, 16'h1111, 16'hC0DE, 3'd4);
    idle();
    chk("mv_dataW", bus.dataW, 16'hC0DE);
    chk("mv_ZNC", {bus.Z, bus.N, bus.C}, 3'b010);

    drive(1, MUL, 16'h0003, 16'h0005, 3'd4);
    repeat (7) idle();
    @(negedge CLK);
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    chk("rstmul_ctl", {bus.busy, bus.RFwrite, bus.done}, 3'b000);
    chk("rstmul_dataW", bus.dataW, 16'h0000);
    chk("rstmul_flags", {bus.Z, bus.N, bus.C}, 3'b000);
    for (int i = 0; i < 12; i++) begin
      idle();
      chk("rstmul_no_write", bus.RFwrite, 1'b0);
    end
    drive(1, ADD, 16'hFFFF, 16'h0002, 3'd5);
    idle();
    chk("post_rst_add", {bus.RFwrite, bus.regW, bus.dataW}, {1'b1, 3'd5, 16'h0001});
    chk("post_rst_ZNC", {bus.Z, bus.N, bus.C}, 3'b001);
    idle();
    idle();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/execute_unit.md
# execute_unit

Execute stage of the 16-bit CPU, directly downstream of the 8×16 register file. It takes the operand pair read from the file (dataA, dataB) together with an opcode and destination register. It computes the result in one cycle, or in 16 cycles for an iterative shift-add multiply. It then drives the register-file write port (RFwrite, regW, dataW) for exactly one cycle. The control FSM asserts start in the cycle after it presents regA/regB, because register-file reads are registered with one cycle of latency.

## Interface
- No parameters. Datapath width is 16 bits and register addresses are 3 bits, matching the register file.
- CLK  input  1  CPU clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to execute; sampled only when busy=0.
- op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SHL, 101 SHR (logical), 110 MUL, 111 MV.
- dstIn  input  3  destination register for this operation.
- dataA  input  16  operand A, from register-file dataA.
- dataB  input  16  operand B, from register-file dataB.
- RFwrite  output  1  one-cycle write strike to the register file.
- regW  output  3  destination register, valid while RFwrite=1.
- dataW  output  16  result, valid while RFwrite=1; holds its last value otherwise.
- busy  output  1  high while a MUL is in progress.
- done  output  1  identical timing to RFwrite; used by the control FSM.
- Z, N, C  output  1 each  zero, negative and carry flags; updated only when a result is produced.

## Operation
- States: IDLE and MUL.
- IDLE, start=1, op≠110:
  - Compute the result combinationally and register it into dataW, regW←dstIn, RFwrite=done=1 in the next cycle.
  - The state remains IDLE, so a new start is accepted every cycle (back-to-back issue).
- IDLE, start=1, op=110:
  - Latch mcand←dataA, mplier←dataB, acc←0, cnt←0, dst←dstIn; go to MUL with busy=1.
- MUL, each cycle:
  - if mplier[0], acc←acc+mcand (mod 2^16);
  - mcand←mcand<<1; mplier←mplier>>1; cnt←cnt+1.
  - When cnt=15, the final iteration result is written to dataW, regW←dst, RFwrite=done=1 next cycle, state←IDLE, busy←0.
- start while busy=1 is ignored: no latch, no queuing, no side effects.
- Arithmetic:
  - ADD: {C,result} = A+B, 17-bit.
  - SUB: result = A−B mod 2^16; C=1 iff A≥B unsigned (no borrow).
  - AND/OR: bitwise.
  - SHL/SHR: shift amount is B[3:0] (0–15), zero fill.
  - MV: result = B.
  - MUL: low 16 bits of the product.
- Flags: Z = (result==0); N = result[15]; C is 0 for every op except ADD and SUB. Flags update in the same cycle that RFwrite is asserted and hold otherwise.
- Reset (any state, including mid-MUL): state←IDLE; RFwrite, done, busy, Z, N, C ← 0; dataW←0x0000; regW←0; internal acc, cnt, mcand, mplier ← 0. Any in-progress MUL is discarded with no write.
- Reset has priority over start in the same cycle.

## Timing
- Single-cycle ops: start sampled at edge k → RFwrite=1 during cycle k+1, for exactly one cycle.
- MUL: start sampled at edge k → busy=1 during cycles k+1 … k+16 → RFwrite=done=1 during cycle k+17, with busy=0 in that cycle.
- A new start is accepted in the same cycle that a MUL's RFwrite is high. In that case its result appears one cycle later.
- RFwrite is never high for two consecutive cycles from the same op.
- All outputs are registered; no combinational path exists from inputs to outputs.

## Test plan
- ADD A=0x7FFF B=0x0001 dst=3, start at edge k → cycle k+1: RFwrite=1, regW=3, dataW=0x8000, N=1, Z=0, C=0; cycle k+2: RFwrite=0.
- SUB A=0x0005 B=0x0005 → dataW=0x0000, Z=1, C=1. Then SUB A=0x0000 B=0x0001 issued back-to-back → dataW=0xFFFF, N=1, C=0 one cycle later.
- MUL A=0x0123 B=0x0010 dst=7 at edge k → busy high cycles k+1 … k+16; RFwrite=1, dataW=0x1230, regW=7 at cycle k+17.
- MUL A=0x0100 B=0x0100 → dataW=0x0000, Z=1, C=0. An ADD start pulsed during busy causes no write and no change to the result.
- SHL A=0x0001 B=0x001F (amount 15) → dataW=0x8000. SHR A=0x8000 B=0x0004 → dataW=0x0800.
- Reset asserted at cycle k+8 of a MUL → next cycle: busy=0, RFwrite=0, dataW=0x0000, flags 0. No RFwrite occurs at k+17. A fresh ADD afterwards completes normally.
